ts_sar_responder: RTL and testbench

// - Digital SAR sequencer on the analog side of the temperature-sensor (TS) link.
// - Consumes the controller's D2A_TS_EN / D2A_TS_START_EN / D2A_TS_CLK / D2A_TS_CHOPPER_CLK.
// - Drives the TS DAC and comparator, and returns A2D_TS_DOUT[7:0] plus an A2D_TS_DETOK pulse.
// - Produces one conversion per START_EN pulse, polarity-corrected for the current chopper phase.

---
 rtl/ts_sar_responder_if.sv | 27 ++
 rtl/ts_sar_responder.sv | 165 ++++++++++++++++
 tb/tb_ts_sar_responder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_sar_responder_if.sv
// Temperature-sensor link bundle: controller-side D2A_* strobes, comparator/DAC pins and the
// A2D_* result. master = controller/analog model, slave = ts_sar_responder.
interface ts_sar_responder_if #(
  parameter int unsigned NBITS = 8
);
  logic             D2A_TS_EN;
  logic             D2A_TS_START_EN;
  logic             D2A_TS_CLK;
  logic             D2A_TS_CHOPPER_CLK;
  logic             cmp_in;
  logic [3:0]       reg_offset;
  logic [NBITS-1:0] dac_code;
  logic             sample_en;
  logic             conv_busy;
  logic [NBITS-1:0] A2D_TS_DOUT;
  logic             A2D_TS_DETOK;

  modport master (
    output D2A_TS_EN, D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, cmp_in, reg_offset,
    input  dac_code, sample_en, conv_busy, A2D_TS_DOUT, A2D_TS_DETOK
  );

  modport slave (
    input  D2A_TS_EN, D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, cmp_in, reg_offset,
    output dac_code, sample_en, conv_busy, A2D_TS_DOUT, A2D_TS_DETOK
  );
endinterface

// File: rtl/ts_sar_responder.sv
// Analog-side SAR sequencer for the TS link: one chopper-corrected conversion per START_EN rise.
// Optional output trim (saturating add of reg_offset) enabled by macro TS_SAR_OFFSET_TRIM_EN.
module ts_sar_responder #(
  parameter int unsigned NBITS       = 8,
  parameter int unsigned DETOK_HI    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              RSTn,
  ts_sar_responder_if.slave ts
);

  localparam int unsigned IdxW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned CntW = $clog2(DETOK_HI + 2);
  localparam logic [NBITS-1:0] MsbOnly = {1'b1, {(NBITS - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StWait, StArm, StSample, StConv, StDone} state_e;

  state_e                       state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]  sync_q;
  logic [1:0]                   edge_q;
  logic [NBITS-1:0]             dac_code_q, dac_code_d;
  logic                         sample_en_q, sample_en_d;
  logic                         chop_l_q, chop_l_d;
  logic [IdxW-1:0]              bit_idx_q, bit_idx_d;
  logic [CntW-1:0]              done_cnt_q, done_cnt_d;
  logic [NBITS-1:0]             dout_q, dout_d;
  logic                         detok_q, detok_d;
  logic [NBITS-1:0]             result;
  logic                         en_s, start_s, tsclk_s, chop_s;
  logic                         start_rise, tsclk_rise, cmp_eff;

  // Synchronized bit order: {EN, START_EN, TS_CLK, CHOPPER_CLK}
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sync_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= {ts.D2A_TS_EN, ts.D2A_TS_START_EN, ts.D2A_TS_CLK, ts.D2A_TS_CHOPPER_CLK};
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      edge_q <= {start_s, tsclk_s};
    end
  end

  assign {en_s, start_s, tsclk_s, chop_s} = sync_q[SYNC_STAGES-1];
  assign start_rise = start_s & ~edge_q[1];
  assign tsclk_rise = tsclk_s & ~edge_q[0];
  assign cmp_eff    = ts.cmp_in ^ chop_l_q;

`ifdef TS_SAR_OFFSET_TRIM_EN
  logic signed [NBITS+1:0] trim_sum;
  assign trim_sum = $signed({2'b00, dac_code_q})
                  + $signed({{(NBITS - 2){ts.reg_offset[3]}}, ts.reg_offset});
  always_comb begin
    if (trim_sum[NBITS+1]) begin
      result = '0;
    end else if (trim_sum[NBITS]) begin
      result = '1;
    end else begin
      result = trim_sum[NBITS-1:0];
    end
  end
`else
  assign result = dac_code_q;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      dac_code_q  <= '0;
      sample_en_q <= 1'b0;
      chop_l_q    <= 1'b0;
      bit_idx_q   <= IdxW'(NBITS - 1);
      done_cnt_q  <= '0;
      dout_q      <= '0;
      detok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dac_code_q  <= dac_code_d;
      sample_en_q <= sample_en_d;
      chop_l_q    <= chop_l_d;
      bit_idx_q   <= bit_idx_d;
      done_cnt_q  <= done_cnt_d;
      dout_q      <= dout_d;
      detok_q     <= detok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dac_code_d  = dac_code_q;
    sample_en_d = sample_en_q;
    chop_l_d    = chop_l_q;
    bit_idx_d   = bit_idx_q;
    done_cnt_d  = done_cnt_q;
    dout_d      = dout_q;
    detok_d     = detok_q;
    if (!en_s) begin
      // Disable wins everywhere; the last result stays on A2D_TS_DOUT.
      state_d     = StIdle;
      dac_code_d  = '0;
      sample_en_d = 1'b0;
      detok_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWait;
        StWait: begin
          if (start_rise) state_d = StArm;
        end
        StArm: begin
          if (tsclk_rise) begin
            state_d     = StSample;
            chop_l_d    = chop_s;
            sample_en_d = 1'b1;
          end
        end
        StSample: begin
          if (tsclk_rise) begin
            state_d     = StConv;
            sample_en_d = 1'b0;
            dac_code_d  = MsbOnly;
            bit_idx_d   = IdxW'(NBITS - 1);
          end
        end
        StConv: begin
          if (tsclk_rise) begin
            if (!cmp_eff) dac_code_d[bit_idx_q] = 1'b0;
            if (bit_idx_q != '0) begin
              dac_code_d[bit_idx_q - IdxW'(1)] = 1'b1;
              bit_idx_d = bit_idx_q - IdxW'(1);
            end else begin
              state_d    = StDone;
              done_cnt_d = '0;
            end
          end
        end
        StDone: begin
          // cnt 0: publish result; 1..DETOK_HI: DETOK high; DETOK_HI+1: leave.
          if (done_cnt_q == CntW'(DETOK_HI + 1)) begin
            detok_d    = 1'b0;
            dac_code_d = '0;
            state_d    = StWait;
          end else begin
            if (done_cnt_q == '0) begin
              dout_d = result;
            end else begin
              detok_d = 1'b1;
            end
            done_cnt_d = done_cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign ts.dac_code     = dac_code_q;
  assign ts.sample_en    = sample_en_q;
  assign ts.conv_busy    = (state_q == StSample) || (state_q == StConv) || (state_q == StDone);
  assign ts.A2D_TS_DOUT  = dout_q;
  assign ts.A2D_TS_DETOK = detok_q;

endmodule

// File: tb/tb_ts_sar_responder.sv
// Self-checking bench for ts_sar_responder: behavioural comparator, DETOK/DOUT scoreboard.
module tb_ts_sar_responder;
  localparam int unsigned NBITS       = 8;
  localparam int unsigned DETOK_HI    = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic RSTn;
  always #5 clk = ~clk;

  ts_sar_responder_if #(.NBITS(NBITS)) bus ();

  ts_sar_responder #(
    .NBITS      (NBITS),
    .DETOK_HI   (DETOK_HI),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk (clk),
    .RSTn(RSTn),
    .ts  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Analog model: the comparator polarity follows the chopper phase of the current conversion.
  logic [7:0] target    = 8'h00;
  logic       conv_chop = 1'b0;
  assign bus.cmp_in = (target >= bus.dac_code) ^ conv_chop;

  logic [7:0] exp_q[$];
  logic [7:0] trial_q[$];
  logic       detok_prev = 1'b0;
  logic [7:0] dout_prev  = 8'h00;
  logic [7:0] cur_exp    = 8'h00;
  int         hi_cnt     = 0;

  function automatic logic [7:0] model(input logic [7:0] code);
`ifdef TS_SAR_OFFSET_TRIM_EN
    int v;
    v = int'(code) + (bus.reg_offset[3] ? int'(bus.reg_offset) - 16 : int'(bus.reg_offset));
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
`else
    return code;
`endif
  endfunction

  // Scoreboard: every DETOK rise must match a queued expectation.
  always @(negedge clk) begin
    if (bus.A2D_TS_DETOK && !detok_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL detok_unexpected: DETOK rose with DOUT=%h, required no pulse",
                 bus.A2D_TS_DOUT);
      end else begin
        cur_exp = exp_q.pop_front();
        if (bus.A2D_TS_DOUT !== cur_exp) begin
          n_errors++;
          $display("FAIL dout: got %h, required %h", bus.A2D_TS_DOUT, cur_exp);
        end
        n_checks++;
        if (dout_prev !== cur_exp) begin
          n_errors++;
          $display("FAIL dout_lead: DOUT 1 clk before DETOK %h, required %h", dout_prev, cur_exp);
        end
      end
      hi_cnt = 1;
    end else if (bus.A2D_TS_DETOK) begin
      hi_cnt++;
      n_checks++;
      if (bus.A2D_TS_DOUT !== cur_exp) begin
        n_errors++;
        $display("FAIL dout_hold: got %h during DETOK, required %h", bus.A2D_TS_DOUT, cur_exp);
      end
    end else if (detok_prev) begin
      n_checks++;
      if (hi_cnt != int'(DETOK_HI)) begin
        n_errors++;
        $display("FAIL detok_width: got %0d clks, required %0d", hi_cnt, DETOK_HI);
      end
    end
    detok_prev = bus.A2D_TS_DETOK;
    dout_prev  = bus.A2D_TS_DOUT;
  end

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tsclk_pulse();
    bus.D2A_TS_CLK = 1'b1;
    wait_clks(6);
    bus.D2A_TS_CLK = 1'b0;
    wait_clks(6);
  endtask

  task automatic start_pulse();
    bus.D2A_TS_START_EN = 1'b1;
    wait_clks(6);
    bus.D2A_TS_START_EN = 1'b0;
    wait_clks(6);
  endtask

  task automatic run_frame(input logic [7:0] tgt, input logic chop, input bit toggle_mid,
                           input bit check_trials, input bit start_mid);
    logic [7:0] t;
    target = tgt;
    conv_chop = chop;
    bus.D2A_TS_CHOPPER_CLK = chop;
    exp_q.push_back(model(tgt));
    start_pulse();
    n_checks++;
    if (bus.conv_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_arm: got %b, required 0", bus.conv_busy);
    end
    tsclk_pulse();
    n_checks++;
    if (bus.sample_en !== 1'b1 || bus.conv_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL sample: sample_en=%b busy=%b, required 1 1", bus.sample_en, bus.conv_busy);
    end
    tsclk_pulse();
    n_checks++;
    if (bus.sample_en !== 1'b0 || bus.dac_code !== 8'h80) begin
      n_errors++;
      $display("FAIL conv_entry: sample_en=%b dac=%h, required 0 80", bus.sample_en, bus.dac_code);
    end
    for (int k = 0; k < 8; k++) begin
      if (check_trials && trial_q.size() > 0) begin
        t = trial_q.pop_front();
        n_checks++;
        if (bus.dac_code !== t) begin
          n_errors++;
          $display("FAIL trial[%0d]: got %h, required %h", k, bus.dac_code, t);
        end
      end
      if (toggle_mid && k == 3) bus.D2A_TS_CHOPPER_CLK = ~bus.D2A_TS_CHOPPER_CLK;
      if (start_mid && k == 2) start_pulse();
      tsclk_pulse();
    end
    wait_clks(6);
    n_checks++;
    if (bus.conv_busy !== 1'b0 || bus.dac_code !== 8'h00) begin
      n_errors++;
      $display("FAIL frame_end: busy=%b dac=%h, required 0 00", bus.conv_busy, bus.dac_code);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL detok_missing: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    bus.D2A_TS_EN          = 1'($urandom);
    bus.D2A_TS_START_EN    = 1'($urandom);
    bus.D2A_TS_CLK         = 1'($urandom);
    bus.D2A_TS_CHOPPER_CLK = 1'($urandom);
    bus.reg_offset         = 4'($urandom);
    wait_clks(3);
    n_checks++;
    if ({bus.dac_code, bus.sample_en, bus.conv_busy, bus.A2D_TS_DOUT, bus.A2D_TS_DETOK} !== '0)
    begin
      n_errors++;
      $display("FAIL reset_outputs: dac=%h se=%b busy=%b dout=%h detok=%b, required all 0",
               bus.dac_code, bus.sample_en, bus.conv_busy, bus.A2D_TS_DOUT, bus.A2D_TS_DETOK);
    end
    bus.D2A_TS_EN = 1'b0;
    bus.D2A_TS_START_EN = 1'b0;
    bus.D2A_TS_CLK = 1'b0;
    bus.reg_offset = 4'h0;
    RSTn = 1'b1;
    start_pulse();
    tsclk_pulse();
    tsclk_pulse();
    n_checks++;
    if (bus.conv_busy !== 1'b0 || bus.sample_en !== 1'b0 || bus.dac_code !== 8'h00) begin
      n_errors++;
      $display("FAIL idle_hold: busy=%b se=%b dac=%h, required 0 0 00",
               bus.conv_busy, bus.sample_en, bus.dac_code);
    end
    bus.D2A_TS_EN = 1'b1;
    wait_clks(6);
  endtask

  task automatic test_chop0();
    logic [7:0] seq [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
    for (int i = 0; i < 8; i++) trial_q.push_back(seq[i]);
    run_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_chop1();
    run_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_en_drop();
    logic [7:0] held;
    held = bus.A2D_TS_DOUT;
    target = 8'h33;
    conv_chop = 1'b0;
    bus.D2A_TS_CHOPPER_CLK = 1'b0;
    start_pulse();
    for (int i = 0; i < 6; i++) tsclk_pulse();
    bus.D2A_TS_EN = 1'b0;
    wait_clks(SYNC_STAGES + 1);
    n_checks++;
    if (bus.conv_busy !== 1'b0 || bus.dac_code !== 8'h00 || bus.sample_en !== 1'b0 ||
        bus.A2D_TS_DETOK !== 1'b0) begin
      n_errors++;
      $display("FAIL en_drop: busy=%b dac=%h se=%b detok=%b, required 0 00 0 0",
               bus.conv_busy, bus.dac_code, bus.sample_en, bus.A2D_TS_DETOK);
    end
    for (int i = 0; i < 4; i++) tsclk_pulse();
    wait_clks(10);
    n_checks++;
    if (bus.A2D_TS_DOUT !== held) begin
      n_errors++;
      $display("FAIL dout_keep: got %h, required %h", bus.A2D_TS_DOUT, held);
    end
    bus.D2A_TS_EN = 1'b1;
    wait_clks(6);
    run_frame(8'hA7, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    target = 8'h9C;
    start_pulse();
    for (int i = 0; i < 4; i++) tsclk_pulse();
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({bus.dac_code, bus.sample_en, bus.conv_busy, bus.A2D_TS_DOUT, bus.A2D_TS_DETOK} !== '0)
    begin
      n_errors++;
      $display("FAIL reset_mid: dac=%h se=%b busy=%b dout=%h, required all 0",
               bus.dac_code, bus.sample_en, bus.conv_busy, bus.A2D_TS_DOUT);
    end
    wait_clks(2);
    RSTn = 1'b1;
    wait_clks(6);
    run_frame(8'h9C, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_offset_trim();
    bus.reg_offset = 4'h7;
    run_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.reg_offset = 4'h8;
    run_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.reg_offset = 4'hF;
    run_frame(8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.reg_offset = 4'h0;
  endtask

  task automatic test_back_to_back();
    run_frame(8'h6E, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      run_frame(8'($urandom_range(0, 255)), 1'(i % 2), 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_chop0();
    test_chop1();
    test_en_drop();
    test_reset_mid();
    test_offset_trim();
    test_back_to_back();
    wait_clks(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
